mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage data-bus controller. Sits between the M pipeline register and the M->W register.
- Turns the load/store held in M into one dbus transaction: byte-lane strobe, shifted store data, valid/addr_ok/data_ok handshake.
- Stalls the pipeline until the response is safe to hand to W.
- Handles flushes that arrive while a bus transaction is in flight.

Parameters:
- WATCHDOG_CYCLES, 0, cycles to wait for data_ok after addr_ok before raising bus_err; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- MemReadM  in  1  load in M
- MemWriteM  in  1  store in M
- SizeM  in  msize_t  access size (MSIZE1/2/4)
- ALUOutM  in  word_t  effective address
- WriteDataM  in  word_t  unshifted store data
- FlushM  in  1  kill the instruction in M
- StallExtM  in  1  stall of M from other sources (hazard unit)
- dreq  out  dbus_req_t  data-bus request
- dresp  in  dbus_resp_t  data-bus response
- dresp_out  out  dbus_resp_t  response presented to the W register
- StallMemM  out  1  stall request from this block
- AdEL  out  1  misaligned load
- AdES  out  1  misaligned store
- bus_err  out  1  watchdog expiry, one-cycle pulse

Behaviour:
- Access = (MemReadM|MemWriteM) & ~FlushM & aligned.
- Aligned: MSIZE4 needs addr[1:0]==0; MSIZE2 needs addr[0]==0; MSIZE1 always aligned.
- Strobe:
  - Loads: 0000.
  - Store MSIZE1: 0001<<addr[1:0].
  - Store MSIZE2: 0011<<addr[1:0].
  - Store MSIZE4: 1111.
- dreq.data = WriteDataM << (8*addr[1:0]).
- dreq.addr = ALUOutM, dreq.size = SizeM.
- States:
  - IDLE: access present -> dreq.valid=1. If addr_ok&data_ok same cycle, go to HOLD. If addr_ok only, go to RESP. Otherwise go to REQ.
  - REQ: dreq.valid=1 and all dreq fields stable. addr_ok&data_ok -> HOLD; addr_ok -> RESP.
  - RESP: dreq.valid=0, waiting for data_ok. data_ok -> capture dresp into buffer, go to HOLD.
  - HOLD: buffered response driven on dresp_out. When ~StallExtM, return to IDLE; the W register samples dresp_out that same edge.
  - DRAIN: entered from RESP on FlushM. Waits for data_ok, discards the data, then returns to IDLE.
- StallMemM:
  - =1 in IDLE with an access and no same-cycle data_ok.
  - =1 in REQ and RESP until data_ok arrives.
  - =1 in DRAIN whenever M holds a new access.
  - =0 in HOLD.
- dresp_out: in HOLD it is the buffer; a same-cycle data_ok is passed straight through; otherwise all zeros.
- Flush:
  - In IDLE/REQ before addr_ok: drop the request, dreq.valid=0 next cycle, go to IDLE.
  - After addr_ok: go to DRAIN. The bus is never abandoned.
  - Flush in HOLD: drop the buffer, go to IDLE.
- Misaligned access: no request is issued. AdEL/AdES is driven combinationally while the instruction sits in M; StallMemM=0.
- Watchdog: counter clears on addr_ok and counts in RESP/DRAIN. At WATCHDOG_CYCLES it pulses bus_err and forces IDLE.
- Reset: state IDLE, buffer 0, counter 0, dreq='0, dresp_out='0, StallMemM=0, AdEL=AdES=0, bus_err=0. Reset mid-transaction abandons it.

Optional Feature:
- MEM_ADDR_EXC_EN defined: misalignment checking, AdEL/AdES, and request suppression as above.
- Undefined: AdEL/AdES tied 0. The address is aligned down (MSIZE4 clears [1:0], MSIZE2 clears [0]) and the request is always issued.

Decomposition:
- Shared type package: msize_t, dbus_req_t, dbus_resp_t, word_t, state enum mem_state_t {IDLE, REQ, RESP, HOLD, DRAIN}, and strobe lookup constants.
- One natural sub-module: mem_lane_align (combinational strobe/shift generation).

Test Plan:
- Store MSIZE1, ALUOutM=0x80000003, WriteDataM=0x000000AB, addr_ok and data_ok in the same cycle -> strobe 1000, dreq.data=0xAB000000, StallMemM low after 1 cycle.
- Load MSIZE4 at 0x80000010, addr_ok after 3 cycles, data_ok 2 cycles later with 0x12345678 -> dreq.valid held with stable fields for 3 cycles; dresp_out.data=0x12345678; stall lasts exactly 5 cycles.
- Load completes while StallExtM=1 for 4 cycles -> HOLD keeps dresp_out=0x12345678 until StallExtM drops, then IDLE.
- FlushM one cycle after addr_ok, data_ok 3 cycles later, new load in M -> DRAIN; new dreq.valid only in the cycle after the discarded data_ok.
- With MEM_ADDR_EXC_EN, MSIZE2 load at 0x80000001 -> AdEL=1, dreq.valid=0, StallMemM=0. Without the macro -> request issued at 0x80000000.
- WATCHDOG_CYCLES=8, addr_ok with no data_ok -> bus_err pulse at cycle 8, state IDLE, StallMemM low.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-stage data-bus controller: access sizes,
// dbus request/response records, controller states and byte-lane strobes.
package mem_access_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic       valid;
    word_t      addr;
    msize_t     size;
    logic [3:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } mem_state_t;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Lane mask of an access placed at byte offset 0.
  function automatic logic [3:0] baseStrobe(input msize_t size);
    case (size)
      MSIZE1:  return STRB_BYTE;
      MSIZE2:  return STRB_HALF;
      default: return STRB_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane placement for a dbus access: write strobe and store data shifted
// to the lanes selected by the low address bits. Purely combinational.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0] addrLo,
  input  msize_t     size,
  input  logic       isStore,
  input  word_t      wdata,
  output logic [3:0] strobe,
  output word_t      data
);

  // Loads never write lanes; stores move their mask and data up by the offset.
  always_comb begin
    strobe = isStore ? (baseStrobe(size) << addrLo) : STRB_NONE;
    data   = wdata << {addrLo, 3'b000};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus controller. Converts the load/store in M into one
// dbus transaction, stalls the pipe until the response can be handed to W,
// and keeps the bus consistent across flushes.
// Build option: MEM_ADDR_EXC_EN enables misalignment exceptions (AdEL/AdES)
// with request suppression; without it the address is aligned down instead.
//
// state | meaning
// IDLE  | no transaction open; a new access is presented straight from M
// REQ   | request presented, waiting for addr_ok; fields held in a register
// RESP  | address accepted, waiting for data_ok
// HOLD  | response buffered while M is held by an external stall
// DRAIN | address accepted for a flushed access; data will be discarded
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MemReadM,
  input  logic       MemWriteM,
  input  msize_t     SizeM,
  input  word_t      ALUOutM,
  input  word_t      WriteDataM,
  input  logic       FlushM,
  input  logic       StallExtM,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output dbus_resp_t dresp_out,
  output logic       StallMemM,
  output logic       AdEL,
  output logic       AdES,
  output logic       bus_err
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_REQ   = REQ;
  localparam logic [2:0] S_RESP  = RESP;
  localparam logic [2:0] S_HOLD  = HOLD;
  localparam logic [2:0] S_DRAIN = DRAIN;

  localparam int WdW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG_CYCLES - 1);

  logic [2:0]     stateQ, stateD;
  dbus_resp_t     bufQ;
  dbus_req_t      reqHeldQ;
  dbus_req_t      curReq;
  logic [WdW-1:0] wdCntQ;
  word_t          effAddr;
  logic           aligned;
  logic           access;
  logic           wdFire;
  logic           captureBuf;
  logic           clearBuf;
  logic           loadReq;
  logic [3:0]     laneStrobe;
  word_t          laneData;

  // Effective address and alignment of the instruction sitting in M.
  always_comb begin
    aligned = 1'b1;
    effAddr = ALUOutM;
`ifdef MEM_ADDR_EXC_EN
    case (SizeM)
      MSIZE4:  aligned = (ALUOutM[1:0] == 2'b00);
      MSIZE2:  aligned = ~ALUOutM[0];
      default: aligned = 1'b1;
    endcase
`else
    case (SizeM)
      MSIZE4:  effAddr[1:0] = 2'b00;
      MSIZE2:  effAddr[0]   = 1'b0;
      default: effAddr      = ALUOutM;
    endcase
`endif
    access = (MemReadM | MemWriteM) & ~FlushM & aligned;
  end

`ifdef MEM_ADDR_EXC_EN
  assign AdEL = ~reset & MemReadM  & ~FlushM & ~aligned;
  assign AdES = ~reset & MemWriteM & ~FlushM & ~aligned;
`else
  assign AdEL = 1'b0;
  assign AdES = 1'b0;
`endif

  mem_lane_align uLaneAlign (
    .addrLo  (effAddr[1:0]),
    .size    (SizeM),
    .isStore (MemWriteM),
    .wdata   (WriteDataM),
    .strobe  (laneStrobe),
    .data    (laneData)
  );

  // Request as it would be issued this cycle from the M register.
  always_comb begin
    curReq        = '0;
    curReq.valid  = 1'b1;
    curReq.addr   = effAddr;
    curReq.size   = SizeM;
    curReq.strobe = laneStrobe;
    curReq.data   = laneData;
  end

  assign wdFire  = (WATCHDOG_CYCLES != 0) && ((stateQ == S_RESP) || (stateQ == S_DRAIN))
                   && ~dresp.data_ok && (wdCntQ == WdLast);
  assign bus_err = wdFire & ~reset;

  // Next state and bus/pipe outputs. A completed response is buffered only
  // when W cannot take it this cycle; otherwise W samples the pass-through.
  always_comb begin
    stateD     = stateQ;
    captureBuf = 1'b0;
    clearBuf   = 1'b0;
    loadReq    = 1'b0;
    dreq       = '0;
    dresp_out  = '0;
    StallMemM  = 1'b0;
    case (stateQ)
      S_IDLE: begin
        if (access) begin
          dreq      = curReq;
          StallMemM = ~dresp.data_ok;
          if (dresp.data_ok) dresp_out = dresp;
          if (dresp.addr_ok && dresp.data_ok) begin
            if (StallExtM) begin
              stateD     = S_HOLD;
              captureBuf = 1'b1;
            end
          end else if (dresp.addr_ok) begin
            stateD = S_RESP;
          end else begin
            stateD  = S_REQ;
            loadReq = 1'b1;
          end
        end
      end
      S_REQ: begin
        dreq       = reqHeldQ;
        dreq.valid = 1'b1;
        StallMemM  = ~dresp.data_ok;
        if (dresp.data_ok) dresp_out = dresp;
        if (dresp.addr_ok && dresp.data_ok) begin
          if (!FlushM && StallExtM) begin
            stateD     = S_HOLD;
            captureBuf = 1'b1;
          end else begin
            stateD = S_IDLE;
          end
        end else if (dresp.addr_ok) begin
          stateD = FlushM ? S_DRAIN : S_RESP;
        end else if (FlushM) begin
          stateD = S_IDLE;
        end
      end
      S_RESP: begin
        StallMemM = ~dresp.data_ok;
        if (dresp.data_ok) begin
          dresp_out = dresp;
          if (!FlushM && StallExtM) begin
            stateD     = S_HOLD;
            captureBuf = 1'b1;
          end else begin
            stateD = S_IDLE;
          end
        end else if (wdFire) begin
          stateD = S_IDLE;
        end else if (FlushM) begin
          stateD = S_DRAIN;
        end
      end
      S_HOLD: begin
        dresp_out = bufQ;
        if (FlushM || !StallExtM) begin
          stateD   = S_IDLE;
          clearBuf = 1'b1;
        end
      end
      S_DRAIN: begin
        StallMemM = access;
        if (dresp.data_ok || wdFire) stateD = S_IDLE;
      end
      default: stateD = S_IDLE;
    endcase
    if (reset) begin
      dreq      = '0;
      dresp_out = '0;
      StallMemM = 1'b0;
    end
  end

  // State, response buffer and held request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= S_IDLE;
      bufQ     <= '0;
      reqHeldQ <= '0;
    end else begin
      stateQ <= stateD;
      if (captureBuf) bufQ <= dresp;
      else if (clearBuf) bufQ <= '0;
      if (loadReq) reqHeldQ <= curReq;
    end
  end

  // Watchdog: restarts when an address is accepted, counts while waiting for data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdCntQ <= '0;
    end else if (dreq.valid && dresp.addr_ok) begin
      wdCntQ <= '0;
    end else if (((stateQ == S_RESP) || (stateQ == S_DRAIN)) && (wdCntQ != WdLast)) begin
      wdCntQ <= wdCntQ + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected requests,
// write-back data and bus_err cycles; a negedge monitor pops and compares.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemReadM, MemWriteM, FlushM, StallExtM;
  msize_t     SizeM;
  word_t      ALUOutM, WriteDataM;
  dbus_req_t  dreq;
  dbus_resp_t dresp, dresp_out;
  logic       StallMemM, AdEL, AdES, bus_err;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WATCHDOG_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .SizeM      (SizeM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .FlushM     (FlushM),
    .StallExtM  (StallExtM),
    .dreq       (dreq),
    .dresp      (dresp),
    .dresp_out  (dresp_out),
    .StallMemM  (StallMemM),
    .AdEL       (AdEL),
    .AdES       (AdES),
    .bus_err    (bus_err)
  );

  typedef struct packed {
    word_t      addr;
    logic [3:0] strobe;
    word_t      data;
    msize_t     size;
  } req_exp_t;

  req_exp_t expReqQ[$];
  word_t    expRespQ[$];
  int       expErrQ[$];
  int       vectors = 0;
  int       miscompares = 0;
  int       cyc = 0;
  req_exp_t monReq;
  word_t    monResp;
  int       monErr;
  int       stallCnt, validCnt;

  // Directed store table: size, address, raw data, expected strobe/data.
  msize_t     tSz[5]     = '{MSIZE1, MSIZE2, MSIZE1, MSIZE4, MSIZE1};
  word_t      tAddr[5]   = '{32'h80000003, 32'h80000002, 32'h80000001, 32'h80000008, 32'h80000002};
  word_t      tWd[5]     = '{32'h000000AB, 32'h0000BEEF, 32'h000000AB, 32'hA5A50F0F, 32'h0000007E};
  logic [3:0] tStrb[5]   = '{4'b1000, 4'b1100, 4'b0010, 4'b1111, 4'b0100};
  word_t      tData[5]   = '{32'hAB000000, 32'hBEEF0000, 32'h0000AB00, 32'hA5A50F0F, 32'h007E0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    vectors++;
    miscompares++;
    $display("FAIL %s: got 0x%08h, expected no event", name, got);
  endtask

  // Monitor: request handshakes, responses taken by W, and bus errors.
  always @(negedge clk) begin
    if (!reset) begin
      if (dreq.valid && dresp.addr_ok) begin
        if (expReqQ.size() == 0) unexpected("unexpected_req", dreq.addr);
        else begin
          monReq = expReqQ.pop_front();
          check("req_addr",   dreq.addr, monReq.addr);
          check("req_strobe", 32'(dreq.strobe), 32'(monReq.strobe));
          check("req_data",   dreq.data, monReq.data);
          check("req_size",   32'(dreq.size), 32'(monReq.size));
        end
      end
      if (dresp_out.data_ok && !StallMemM && !StallExtM && !FlushM) begin
        if (expRespQ.size() == 0) unexpected("unexpected_wb", dresp_out.data);
        else begin
          monResp = expRespQ.pop_front();
          check("wb_data", dresp_out.data, monResp);
        end
      end
      if (bus_err) begin
        if (expErrQ.size() == 0) unexpected("unexpected_bus_err", cyc);
        else begin
          monErr = expErrQ.pop_front();
          check("bus_err_cycle", cyc, monErr);
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleM();
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    FlushM    = 1'b0;
    StallExtM = 1'b0;
    dresp     = '0;
  endtask

  task automatic issue(input logic rd, input msize_t sz, input word_t addr, input word_t wd);
    MemReadM   = rd;
    MemWriteM  = ~rd;
    SizeM      = sz;
    ALUOutM    = addr;
    WriteDataM = wd;
  endtask

  task automatic driveBus(input logic aok, input logic dok, input word_t data);
    dresp.addr_ok = aok;
    dresp.data_ok = dok;
    dresp.data    = data;
  endtask

  task automatic pushReq(input word_t addr, input logic [3:0] strb, input word_t data, input msize_t sz);
    req_exp_t e;
    e.addr = addr; e.strobe = strb; e.data = data; e.size = sz;
    expReqQ.push_back(e);
  endtask

  initial begin
    // Reset with an access and a bus response present: every output quiet.
    reset = 1'b1;
    idleM();
    issue(1'b1, MSIZE4, 32'h80000010, 32'h0);
    driveBus(1'b1, 1'b1, 32'h5);
    @(negedge clk);
    check("rst_dreq_valid", 32'(dreq.valid), 0);
    check("rst_dreq_addr", dreq.addr, 0);
    check("rst_stall", 32'(StallMemM), 0);
    check("rst_dresp_out", dresp_out.data, 0);
    check("rst_bus_err", 32'(bus_err), 0);
    check("rst_adel", 32'(AdEL), 0);
    nextCycle();
    reset = 1'b0;
    idleM();
    nextCycle();

    // Single-cycle stores: lane placement, no stall.
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, tSz[i], tAddr[i], tWd[i]);
      driveBus(1'b1, 1'b1, word_t'(i + 1));
      pushReq(tAddr[i], tStrb[i], tData[i], tSz[i]);
      expRespQ.push_back(word_t'(i + 1));
      @(negedge clk);
      check("store_stall", 32'(StallMemM), 0);
      nextCycle();
    end
    idleM();
    nextCycle();

    // Load with addr_ok in its 4th cycle and data_ok two cycles later.
    issue(1'b1, MSIZE4, 32'h80000010, 32'h55AA1234);
    pushReq(32'h80000010, 4'b0000, 32'h55AA1234, MSIZE4);
    expRespQ.push_back(32'h12345678);
    stallCnt = 0;
    validCnt = 0;
    for (int c = 0; c < 6; c++) begin
      driveBus(c == 3, c == 5, (c == 5) ? 32'h12345678 : 32'h0);
      @(negedge clk);
      stallCnt += int'(StallMemM);
      validCnt += int'(dreq.valid);
      if (dreq.valid) check("load_held_addr", dreq.addr, 32'h80000010);
      nextCycle();
    end
    idleM();
    check("load_stall_cycles", stallCnt, 5);
    check("load_valid_cycles", validCnt, 4);
    nextCycle();

    // Load completing under an external stall: response held in HOLD.
    issue(1'b1, MSIZE4, 32'h80000020, 32'h0);
    pushReq(32'h80000020, 4'b0000, 32'h0, MSIZE4);
    expRespQ.push_back(32'h12345678);
    driveBus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    nextCycle();
    StallExtM = 1'b1;
    driveBus(1'b0, 1'b1, 32'h12345678);
    @(negedge clk);
    check("ext_stall_mem_low", 32'(StallMemM), 0);
    nextCycle();
    driveBus(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_data", dresp_out.data, 32'h12345678);
      check("hold_no_req", 32'(dreq.valid), 0);
      nextCycle();
    end
    StallExtM = 1'b0;
    @(negedge clk);
    check("hold_release_data", dresp_out.data, 32'h12345678);
    nextCycle();
    idleM();
    @(negedge clk);
    check("after_hold_ok", 32'(dresp_out.data_ok), 0);
    check("after_hold_data", dresp_out.data, 0);
    nextCycle();

    // Flush after addr_ok: drain, then the next load issues after the discard.
    issue(1'b1, MSIZE4, 32'h80000030, 32'h0);
    pushReq(32'h80000030, 4'b0000, 32'h0, MSIZE4);
    driveBus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    nextCycle();
    FlushM = 1'b1;
    driveBus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("flush_resp_valid", 32'(dreq.valid), 0);
    nextCycle();
    FlushM = 1'b0;
    issue(1'b1, MSIZE4, 32'h80000040, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("drain_valid", 32'(dreq.valid), 0);
      check("drain_stall", 32'(StallMemM), 1);
      nextCycle();
    end
    driveBus(1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    check("drain_discard_valid", 32'(dreq.valid), 0);
    check("drain_discard_data", dresp_out.data, 0);
    check("drain_discard_stall", 32'(StallMemM), 1);
    nextCycle();
    driveBus(1'b1, 1'b1, 32'hCAFEF00D);
    pushReq(32'h80000040, 4'b0000, 32'h0, MSIZE4);
    expRespQ.push_back(32'hCAFEF00D);
    @(negedge clk);
    check("post_drain_valid", 32'(dreq.valid), 1);
    check("post_drain_stall", 32'(StallMemM), 0);
    nextCycle();
    idleM();
    nextCycle();

    // Flush while the request is still waiting for addr_ok.
    issue(1'b1, MSIZE4, 32'h80000060, 32'h0);
    @(negedge clk);
    nextCycle();
    FlushM = 1'b1;
    @(negedge clk);
    check("req_flush_valid_now", 32'(dreq.valid), 1);
    nextCycle();
    idleM();
    @(negedge clk);
    check("req_flush_valid_next", 32'(dreq.valid), 0);
    check("req_flush_stall", 32'(StallMemM), 0);
    nextCycle();

    // Misaligned accesses.
`ifdef MEM_ADDR_EXC_EN
    issue(1'b1, MSIZE2, 32'h80000001, 32'h11223344);
    @(negedge clk);
    check("mis_load_adel", 32'(AdEL), 1);
    check("mis_load_ades", 32'(AdES), 0);
    check("mis_load_valid", 32'(dreq.valid), 0);
    check("mis_load_stall", 32'(StallMemM), 0);
    nextCycle();
    issue(1'b0, MSIZE4, 32'h80000006, 32'h0BADF00D);
    @(negedge clk);
    check("mis_store_ades", 32'(AdES), 1);
    check("mis_store_adel", 32'(AdEL), 0);
    check("mis_store_valid", 32'(dreq.valid), 0);
    nextCycle();
`else
    issue(1'b1, MSIZE2, 32'h80000001, 32'h11223344);
    pushReq(32'h80000000, 4'b0000, 32'h11223344, MSIZE2);
    expRespQ.push_back(32'h0000BEEF);
    driveBus(1'b1, 1'b1, 32'h0000BEEF);
    @(negedge clk);
    check("mis_load_adel", 32'(AdEL), 0);
    check("mis_load_valid", 32'(dreq.valid), 1);
    nextCycle();
    issue(1'b0, MSIZE4, 32'h80000006, 32'h0BADF00D);
    pushReq(32'h80000004, 4'b1111, 32'h0BADF00D, MSIZE4);
    expRespQ.push_back(32'h0);
    driveBus(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    check("mis_store_ades", 32'(AdES), 0);
    nextCycle();
`endif
    idleM();
    nextCycle();

    // Watchdog: addr_ok without data_ok, bus_err eight cycles later.
    issue(1'b1, MSIZE4, 32'h80000050, 32'h0);
    pushReq(32'h80000050, 4'b0000, 32'h0, MSIZE4);
    expErrQ.push_back(cyc + 8);
    driveBus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    nextCycle();
    driveBus(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 7; c++) nextCycle();
    @(negedge clk);
    check("wd_pulse", 32'(bus_err), 1);
    nextCycle();
    idleM();
    @(negedge clk);
    check("wd_after_stall", 32'(StallMemM), 0);
    check("wd_after_valid", 32'(dreq.valid), 0);
    check("wd_after_pulse", 32'(bus_err), 0);
    nextCycle();

    // Reset in the middle of a transaction abandons it.
    issue(1'b1, MSIZE4, 32'h80000070, 32'h0);
    pushReq(32'h80000070, 4'b0000, 32'h0, MSIZE4);
    driveBus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    nextCycle();
    reset = 1'b1;
    idleM();
    @(negedge clk);
    check("midrst_stall", 32'(StallMemM), 0);
    nextCycle();
    reset = 1'b0;
    driveBus(1'b0, 1'b1, 32'h00000099);
    @(negedge clk);
    check("midrst_stale_data", dresp_out.data, 0);
    check("midrst_stale_stall", 32'(StallMemM), 0);
    nextCycle();
    idleM();
    nextCycle();

    check("left_req", expReqQ.size(), 0);
    check("left_wb", expRespQ.size(), 0);
    check("left_bus_err", expErrQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
